fsm_style3_run_ctrl: RTL and testbench

- Parametrised successor to the single-bit start/done Moore FSM (style 3: next-state logic plus registered outputs).
- Accepts a start request with a programmable run length and runs a one-cycle LOAD phase, then counts down the RUN phase.
- Signals completion with a configurable-width `done` pulse; supports abort and zero-length error reporting.
- Acts as the generic sequencing controller for datapath blocks that need a timed "busy window".

---
 rtl/fsm_style3_run_ctrl.sv | 152 +++++++++++++++
 tb/tb_fsm_style3_run_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fsm_style3_run_ctrl.sv
// Run-length sequencing controller: IDLE -> LOAD -> RUN (count down) -> DONE, all outputs registered.
// Optional FSM_RESTART_EN: a start on the final DONE cycle launches the next run with no idle gap.
module fsm_style3_run_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DONE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             abort_ack,
  output logic [CNT_W-1:0] count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int               HOLD_W    = $clog2(DONE_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(DONE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_len_q;
  logic [HOLD_W-1:0] r_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_ack;
  logic [CNT_W-1:0]  r_count;

  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_len_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic              w_ack_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_len_zero;

  assign w_len_zero = (len == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len_q;
    w_hold_nxt  = r_hold;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_ack_nxt   = 1'b0;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (start && !w_len_zero) begin
          w_state_nxt = S_LOAD;
          w_len_nxt   = len;
          w_busy_nxt  = 1'b1;
        end else if (start) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_hold_nxt  = HOLD_INIT;
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_count_nxt = '0;
          w_ack_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_RUN;
          w_count_nxt = r_len_q;
        end
      end
      S_RUN: begin
        // abort takes priority over the count==1 completion
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_count_nxt = '0;
          w_ack_nxt   = 1'b1;
        end else if (r_count == CNT_ONE) begin
          w_state_nxt = S_DONE;
          w_count_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b0;
          w_hold_nxt  = HOLD_INIT;
        end else begin
          w_count_nxt = r_count - CNT_ONE;
        end
      end
      default: begin
        if (r_hold != '0) begin
          w_hold_nxt = r_hold - 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b0;
          w_err_nxt   = 1'b0;
`ifdef FSM_RESTART_EN
          if (start && !w_len_zero) begin
            w_state_nxt = S_LOAD;
            w_len_nxt   = len;
            w_busy_nxt  = 1'b1;
          end else if (start) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
            w_hold_nxt  = HOLD_INIT;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len_q <= '0;
      r_hold  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ack   <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_len_q <= w_len_nxt;
      r_hold  <= w_hold_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_ack   <= w_ack_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign abort_ack = r_ack;
  assign count     = r_count;

endmodule

// File: tb/tb_fsm_style3_run_ctrl.sv
// Directed bench for fsm_style3_run_ctrl: expected output vectors queued per step, compared after each edge.
module tb_fsm_style3_run_ctrl;

  localparam int CNT_W = 8;
  localparam int DC    = 3;
  localparam int OW    = 4 + CNT_W;
  typedef logic [OW-1:0] ov_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             abort = 1'b0;
  logic             busy, done, err, abort_ack;
  logic [CNT_W-1:0] count;

  int  checks = 0;
  int  errors = 0;
  ov_t sb[$];

  fsm_style3_run_ctrl #(.CNT_W(CNT_W), .DONE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .busy(busy), .done(done), .err(err), .abort_ack(abort_ack), .count(count)
  );

  always #5 clk = ~clk;

  function automatic ov_t mk(input logic b, input logic d, input logic e, input logic k, input int c);
    return {b, d, e, k, CNT_W'(c)};
  endfunction

  function automatic ov_t obs();
    return {busy, done, err, abort_ack, count};
  endfunction

  task automatic chk(input string tag, input ov_t o, input ov_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed busy/done/err/ack/count=%b/%b/%b/%b/%0d expected=%b/%b/%b/%b/%0d",
             tag, o[OW-1], o[OW-2], o[OW-3], o[OW-4], o[CNT_W-1:0],
             e[OW-1], e[OW-2], e[OW-3], e[OW-4], e[CNT_W-1:0]);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare after the edge.
  task automatic step(input logic s, input int l, input logic a, input ov_t e, input string tag);
    ov_t exp_v;
    start = s;
    len   = CNT_W'(l);
    abort = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    chk(tag, obs(), exp_v);
  endtask

  // Full run; start pulses during busy and DONE (non-final) cycles must be ignored.
  task automatic run(input int l, input string tag);
    step(1'b1, l, 1'b0, mk(1, 0, 0, 0, 0), {tag, "_load"});
    for (int k = l; k >= 1; k--)
      step(k[0], 8'h33, 1'b0, mk(1, 0, 0, 0, k), {tag, "_run"});
    step(1'b1, 7, 1'b0, mk(0, 1, 0, 0, 0), {tag, "_done"});
    for (int j = 1; j < DC; j++)
      step(1'b1, 7, 1'b1, mk(0, 1, 0, 0, 0), {tag, "_hold"});
    step(1'b0, 0, 1'b1, mk(0, 0, 0, 0, 0), {tag, "_idle"});
    step(1'b0, 0, 1'b1, mk(0, 0, 0, 0, 0), {tag, "_idle_abort"});
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 chk("rst_async", obs(), mk(0, 0, 0, 0, 0));
    #8 rst = 1'b0;
    #2 chk("rst_release", obs(), mk(0, 0, 0, 0, 0));

    run(5, "len5");

    step(1'b1, 0, 1'b0, mk(0, 1, 1, 0, 0), "zl_done");
    for (int j = 1; j < DC; j++)
      step(1'b0, 0, 1'b0, mk(0, 1, 1, 0, 0), "zl_hold");
    step(1'b0, 0, 1'b0, mk(0, 0, 0, 0, 0), "zl_idle");

    step(1'b1, 8, 1'b0, mk(1, 0, 0, 0, 0), "ab8_load");
    for (int k = 8; k >= 3; k--)
      step(1'b0, 0, 1'b0, mk(1, 0, 0, 0, k), "ab8_run");
    step(1'b0, 0, 1'b1, mk(0, 0, 0, 1, 0), "ab8_ack");
    step(1'b0, 0, 1'b0, mk(0, 0, 0, 0, 0), "ab8_ack_drop");
    step(1'b0, 0, 1'b0, mk(0, 0, 0, 0, 0), "ab8_idle");

    step(1'b1, 4, 1'b0, mk(1, 0, 0, 0, 0), "abl_load");
    step(1'b0, 0, 1'b1, mk(0, 0, 0, 1, 0), "abl_ack");
    step(1'b0, 0, 1'b0, mk(0, 0, 0, 0, 0), "abl_idle");

    step(1'b1, 1, 1'b0, mk(1, 0, 0, 0, 0), "ab1_load");
    step(1'b0, 0, 1'b0, mk(1, 0, 0, 0, 1), "ab1_run");
    step(1'b0, 0, 1'b1, mk(0, 0, 0, 1, 0), "ab1_ack");
    step(1'b0, 0, 1'b0, mk(0, 0, 0, 0, 0), "ab1_idle");
    step(1'b0, 0, 1'b0, mk(0, 0, 0, 0, 0), "ab1_no_done");

    step(1'b1, 6, 1'b0, mk(1, 0, 0, 0, 0), "mr_load");
    for (int k = 6; k >= 4; k--)
      step(1'b0, 0, 1'b0, mk(1, 0, 0, 0, k), "mr_run");
    #1 rst = 1'b1;
    #1 chk("mr_async_rst", obs(), mk(0, 0, 0, 0, 0));
    rst = 1'b0;
    step(1'b0, 0, 1'b0, mk(0, 0, 0, 0, 0), "mr_idle");
    run(3, "len3");

    run((1 << CNT_W) - 1, "lenmax");

    step(1'b1, 2, 1'b0, mk(1, 0, 0, 0, 0), "rs_load0");
    step(1'b1, 2, 1'b0, mk(1, 0, 0, 0, 2), "rs_run0");
    step(1'b1, 2, 1'b0, mk(1, 0, 0, 0, 1), "rs_run0");
    for (int j = 0; j < DC; j++)
      step(1'b1, 2, 1'b0, mk(0, 1, 0, 0, 0), "rs_done0");
`ifndef FSM_RESTART_EN
    step(1'b1, 2, 1'b0, mk(0, 0, 0, 0, 0), "rs_gap");
`endif
    step(1'b1, 2, 1'b0, mk(1, 0, 0, 0, 0), "rs_load1");
    step(1'b0, 0, 1'b0, mk(1, 0, 0, 0, 2), "rs_run1");
    step(1'b0, 0, 1'b0, mk(1, 0, 0, 0, 1), "rs_run1");
    for (int j = 0; j < DC; j++)
      step(1'b0, 0, 1'b0, mk(0, 1, 0, 0, 0), "rs_done1");
    step(1'b0, 0, 1'b0, mk(0, 0, 0, 0, 0), "rs_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
